// File: rtl/hollow_polygon_rasterizer.sv
// hollow_polygon_rasterizer
//
// Outline rasterizer for a closed polygon or open polyline of up to MAX_VERTS
// vertices. Each edge is walked with an integer Bresenham stepper and one pixel
// is offered per valid/ready handshake, so downstream stalls never drop pixels.
// Shared vertices are emitted exactly once: every edge is start-inclusive and
// end-exclusive, except the last edge of an open polyline which also emits its
// end point.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               command strobe, sampled only while idle
//   num_verts           vertex count (clamped to MAX_VERTS)
//   closed              1 = closed polygon, 0 = open polyline
//   vx_flat, vy_flat    packed vertex coordinates, vertex i at [i*COORD_W +: COORD_W]
//   color               outline colour, latched at start
//   px, py, pixel_color current pixel, held stable while stalled
//   pixel_valid         pixel present; pixel_ready accepts it
//   busy                command in flight
//   done                one-cycle completion pulse
module hollow_polygon_rasterizer #(
  parameter int unsigned COORD_W   = 8,
  parameter int unsigned COLOR_W   = 24,
  parameter int unsigned MAX_VERTS = 6,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_W-1:0]             num_verts,
  input  logic                         closed,
  input  logic [MAX_VERTS*COORD_W-1:0] vx_flat,
  input  logic [MAX_VERTS*COORD_W-1:0] vy_flat,
  input  logic [COLOR_W-1:0]           color,
  output logic [COORD_W-1:0]           px,
  output logic [COORD_W-1:0]           py,
  output logic [COLOR_W-1:0]           pixel_color,
  output logic                         pixel_valid,
  input  logic                         pixel_ready,
  output logic                         busy,
  output logic                         done
);

  // Two guard bits keep |delta|, err and the step updates from wrapping.
  localparam int unsigned SW = COORD_W + 2;

  typedef enum logic [1:0] {StIdle, StSetup, StDraw, StFinish} state_e;

  state_e state_q;

  logic [COORD_W-1:0]       vx_q [MAX_VERTS];
  logic [COORD_W-1:0]       vy_q [MAX_VERTS];
  logic [CNT_W-1:0]         nv_q;
  logic [CNT_W-1:0]         n_edges_q;
  logic [CNT_W-1:0]         e_q;
  logic                     closed_q;
  logic [COORD_W-1:0]       end_x_q, end_y_q;
  logic signed [SW-1:0]     dx_q, dy_q, err_q;
  logic                     sx_neg_q, sy_neg_q;

  // Command decode.
  logic [CNT_W-1:0] nv_in;
  assign nv_in = (num_verts > CNT_W'(MAX_VERTS)) ? CNT_W'(MAX_VERTS) : num_verts;

  // Edge bookkeeping.
  logic [CNT_W-1:0] e_next, b_idx;
  logic             last_edge, final_edge;
  assign e_next     = e_q + CNT_W'(1);
  assign b_idx      = (e_next == nv_q) ? '0 : e_next;
  assign last_edge  = (e_next == n_edges_q);
  assign final_edge = last_edge && !closed_q;

  // Edge endpoint fetch; a compare-and-select avoids indexing past MAX_VERTS.
  logic [COORD_W-1:0] ax, ay, bx, by;
  always_comb begin
    ax = '0;
    ay = '0;
    bx = '0;
    by = '0;
    for (int i = 0; i < int'(MAX_VERTS); i++) begin
      if (e_q == CNT_W'(i)) begin
        ax = vx_q[i];
        ay = vy_q[i];
      end
      if (b_idx == CNT_W'(i)) begin
        bx = vx_q[i];
        by = vy_q[i];
      end
    end
  end

  // Edge setup arithmetic.
  logic signed [SW-1:0] dx_raw, dy_raw, dx_abs, dy_abs;
  logic                 zero_len;
  always_comb begin
    dx_raw = {2'b00, bx} - {2'b00, ax};
    dy_raw = {2'b00, by} - {2'b00, ay};
    dx_abs = dx_raw[SW-1] ? -dx_raw : dx_raw;
    dy_abs = dy_raw[SW-1] ? -dy_raw : dy_raw;
  end
  assign zero_len = (ax == bx) && (ay == by);

  // Bresenham step; e2 carries one extra bit since it is twice err.
  logic signed [SW:0]   e2, dxw, dyw, ndy;
  logic                 step_x, step_y;
  logic signed [SW-1:0] err_n;
  logic [COORD_W-1:0]   nx, ny;
  always_comb begin
    e2     = {err_q, 1'b0};
    dxw    = {dx_q[SW-1], dx_q};
    dyw    = {dy_q[SW-1], dy_q};
    ndy    = -dyw;
    step_x = (e2 > ndy);
    step_y = (e2 < dxw);
    err_n  = err_q;
    if (step_x) err_n = err_n - dy_q;
    if (step_y) err_n = err_n + dx_q;
    nx = px;
    ny = py;
    if (step_x) nx = sx_neg_q ? px - COORD_W'(1) : px + COORD_W'(1);
    if (step_y) ny = sy_neg_q ? py - COORD_W'(1) : py + COORD_W'(1);
  end

  logic at_end, step_hits_end, draw_exit;
  assign at_end        = (px == end_x_q) && (py == end_y_q);
  assign step_hits_end = (nx == end_x_q) && (ny == end_y_q);
  // The final open edge also emits its end point, so it exits on that pixel.
  assign draw_exit     = pixel_ready && (final_edge ? at_end : step_hits_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < int'(MAX_VERTS); i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      nv_q        <= '0;
      n_edges_q   <= '0;
      e_q         <= '0;
      closed_q    <= 1'b0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      px          <= '0;
      py          <= '0;
      pixel_color <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < int'(MAX_VERTS); i++) begin
              vx_q[i] <= vx_flat[i*COORD_W +: COORD_W];
              vy_q[i] <= vy_flat[i*COORD_W +: COORD_W];
            end
            pixel_color <= color;
            closed_q    <= closed;
            nv_q        <= nv_in;
            n_edges_q   <= closed ? nv_in : nv_in - CNT_W'(1);
            e_q         <= '0;
            if (nv_in < CNT_W'(2)) begin
              // Degenerate command: straight to the completion pulse.
              state_q <= StFinish;
              done    <= 1'b1;
            end else begin
              state_q <= StSetup;
              busy    <= 1'b1;
            end
          end
        end

        StSetup: begin
          if (zero_len && !final_edge) begin
            // Nothing to draw on this edge; its start is the next edge's start.
            if (last_edge) begin
              state_q <= StFinish;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              e_q <= e_next;
            end
          end else begin
            px          <= ax;
            py          <= ay;
            end_x_q     <= bx;
            end_y_q     <= by;
            dx_q        <= dx_abs;
            dy_q        <= dy_abs;
            err_q       <= dx_abs - dy_abs;
            sx_neg_q    <= (bx < ax);
            sy_neg_q    <= (by < ay);
            pixel_valid <= 1'b1;
            state_q     <= StDraw;
          end
        end

        StDraw: begin
          if (pixel_ready) begin
            if (!(final_edge && at_end)) begin
              px    <= nx;
              py    <= ny;
              err_q <= err_n;
            end
            if (draw_exit) begin
              pixel_valid <= 1'b0;
              if (last_edge) begin
                state_q <= StFinish;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                e_q     <= e_next;
                state_q <= StSetup;
              end
            end
          end
        end

        StFinish: begin
          // start is deliberately not sampled here.
          done    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
